// File: rtl/carry_ripple_pkg.sv
// Shared types and constants for the carry-ripple adder sequencer.
//   state_e     : controller FSM states
//   ADDER_WIDTH : default adder operand width
//   ERR_CNT_W   : BIST mismatch counter width
package carry_ripple_pkg;

  localparam int unsigned ADDER_WIDTH = 7;
  localparam int unsigned ERR_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SETTLE      = 2'd1,
    RESP        = 2'd2,
    BIST_SETTLE = 2'd3
  } state_e;

endpackage

// File: rtl/carry_ripple_settle_timer.sv
// Loadable settle down-counter shared by normal and BIST settle phases.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val into the counter (takes priority)
//   load_val   : reload value (settle cycles - 1)
//   zero       : registered flag, high the cycle after the count has sat at zero,
//                giving SETTLE_CYCLES+1 edges from load to expiry
module carry_ripple_settle_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Counter: reload on request, otherwise run down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Expiry flag; a load always clears it so a stale expiry is never seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
    end else begin
      zero <= !load && (cnt == '0);
    end
  end

endmodule

// File: rtl/carry_ripple_seq_ctrl.sv
// Sequencer for the carry-ripple adder macro: request handshake, settle wait,
// sample and return result, plus an exhaustive self-test sweep.
//   req_*      : operand request (valid/ready); req_ready is combinational
//   adder_*    : pins to/from the adder macro
//   res_*      : sampled result (valid/ready) with mismatch flag
//   bist_*     : sweep start pulse, busy/done status, saturating error count
module carry_ripple_seq_ctrl
  import carry_ripple_pkg::*;
#(
  parameter int unsigned WIDTH         = ADDER_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  input  logic                 req_cin,
  output logic [WIDTH-1:0]     adder_a,
  output logic [WIDTH-1:0]     adder_b,
  output logic                 adder_cin,
  input  logic [WIDTH-1:0]     adder_sum,
  input  logic                 adder_cout,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_sum,
  output logic                 res_cout,
  output logic                 res_mismatch,
  input  logic                 bist_start,
  output logic                 bist_busy,
  output logic                 bist_done,
  output logic [ERR_CNT_W-1:0] bist_err_cnt
);

  localparam int unsigned IDX_W = 2 * WIDTH + 1;
  localparam int unsigned SUM_W = WIDTH + 1;

  state_e           state, state_n;
  logic             tmr_load, tmr_zero;
  logic             accept, bist_go, capture, res_clr;
  logic             bist_chk, bist_step, bist_fin;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [SUM_W-1:0] expect_sum;
  logic             mismatch_c;

  carry_ripple_settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .zero     (tmr_zero)
  );

  // Digital reference sum of the operands currently on the adder pins.
  assign expect_sum = SUM_W'({1'b0, adder_a}) + SUM_W'({1'b0, adder_b}) + SUM_W'(adder_cin);
  assign mismatch_c = ({adder_cout, adder_sum} != expect_sum);
  assign idx_nxt    = idx + IDX_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    tmr_load  = 1'b0;
    accept    = 1'b0;
    bist_go   = 1'b0;
    capture   = 1'b0;
    res_clr   = 1'b0;
    bist_chk  = 1'b0;
    bist_step = 1'b0;
    bist_fin  = 1'b0;
    case (state)
      IDLE: begin
        // Sweep start takes priority and masks the request for this cycle.
        if (bist_start) begin
          bist_go  = 1'b1;
          tmr_load = 1'b1;
          state_n  = BIST_SETTLE;
        end else begin
          req_ready = rst_n;
          if (req_valid && rst_n) begin
            accept   = 1'b1;
            tmr_load = 1'b1;
            state_n  = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          capture = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (res_ready) begin
          res_clr = 1'b1;
          state_n = IDLE;
        end
      end
      BIST_SETTLE: begin
        if (tmr_zero) begin
          bist_chk = 1'b1;
          if (&idx) begin
            bist_fin = 1'b1;
            state_n  = IDLE;
          end else begin
            bist_step = 1'b1;
            tmr_load  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: adder pin drive, result capture, sweep bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adder_a      <= '0;
      adder_b      <= '0;
      adder_cin    <= 1'b0;
      res_valid    <= 1'b0;
      res_sum      <= '0;
      res_cout     <= 1'b0;
      res_mismatch <= 1'b0;
      bist_busy    <= 1'b0;
      bist_done    <= 1'b0;
      bist_err_cnt <= '0;
      idx          <= '0;
    end else begin
      if (accept) begin
        adder_a   <= req_a;
        adder_b   <= req_b;
        adder_cin <= req_cin;
      end
      if (bist_go) begin
        idx          <= '0;
        adder_a      <= '0;
        adder_b      <= '0;
        adder_cin    <= 1'b0;
        bist_busy    <= 1'b1;
        bist_done    <= 1'b0;
        bist_err_cnt <= '0;
      end
      if (capture) begin
        res_sum      <= adder_sum;
        res_cout     <= adder_cout;
        res_mismatch <= mismatch_c;
        res_valid    <= 1'b1;
      end
      if (res_clr) begin
        res_valid <= 1'b0;
      end
      if (bist_chk && mismatch_c && (bist_err_cnt != '1)) begin
        bist_err_cnt <= bist_err_cnt + ERR_CNT_W'(1);
      end
      if (bist_step) begin
        idx                           <= idx_nxt;
        {adder_cin, adder_b, adder_a} <= idx_nxt;
      end
      if (bist_fin) begin
        bist_busy <= 1'b0;
        bist_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_carry_ripple_seq_ctrl.sv
// Self-checking bench: a 7-bit instance for the request path and a 5-bit
// instance for full sweeps, each driving a 3-cycle-latency adder model.
module tb_carry_ripple_seq_ctrl;

  localparam int unsigned W7 = 7;
  localparam int unsigned W5 = 5;
  localparam int unsigned SC = 4;
  localparam int unsigned SWEEP5 = (1 << (2 * W5 + 1)) * (SC + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- 7-bit instance ----------------
  logic          rv7 = 1'b0, rr7, rc7 = 1'b0;
  logic [W7-1:0] ra7 = '0, rb7 = '0;
  logic [W7-1:0] aa7, ab7, as7, ss7;
  logic          ac7, ao7, sv7, sr7 = 1'b0, so7, sm7, bs7 = 1'b0, bb7, bd7;
  logic [7:0]    be7;

  carry_ripple_seq_ctrl #(.WIDTH(W7), .SETTLE_CYCLES(SC), .CNT_W(4)) u7 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv7), .req_ready(rr7), .req_a(ra7), .req_b(rb7), .req_cin(rc7),
    .adder_a(aa7), .adder_b(ab7), .adder_cin(ac7), .adder_sum(as7), .adder_cout(ao7),
    .res_valid(sv7), .res_ready(sr7), .res_sum(ss7), .res_cout(so7), .res_mismatch(sm7),
    .bist_start(bs7), .bist_busy(bb7), .bist_done(bd7), .bist_err_cnt(be7)
  );

  // Adder model: ideal sum with optional stuck-at-0 faults, 3-cycle output delay.
  logic       f7_b3 = 1'b0, f7_co = 1'b0;
  logic [7:0] t7, p7_0, p7_1, p7_2;
  assign t7 = {1'b0, aa7} + {1'b0, ab7} + 8'(ac7);
  always @(posedge clk) begin
    p7_0 <= t7 & ~{f7_co, 3'b000, f7_b3, 3'b000};
    p7_1 <= p7_0;
    p7_2 <= p7_1;
  end
  assign as7 = p7_2[6:0];
  assign ao7 = p7_2[7];

  // ---------------- 5-bit instance ----------------
  logic          rv5 = 1'b0, rr5, rc5 = 1'b0;
  logic [W5-1:0] ra5 = '0, rb5 = '0;
  logic [W5-1:0] aa5, ab5, as5, ss5;
  logic          ac5, ao5, sv5, sr5 = 1'b0, so5, sm5, bs5 = 1'b0, bb5, bd5;
  logic [7:0]    be5;

  carry_ripple_seq_ctrl #(.WIDTH(W5), .SETTLE_CYCLES(SC), .CNT_W(4)) u5 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv5), .req_ready(rr5), .req_a(ra5), .req_b(rb5), .req_cin(rc5),
    .adder_a(aa5), .adder_b(ab5), .adder_cin(ac5), .adder_sum(as5), .adder_cout(ao5),
    .res_valid(sv5), .res_ready(sr5), .res_sum(ss5), .res_cout(so5), .res_mismatch(sm5),
    .bist_start(bs5), .bist_busy(bb5), .bist_done(bd5), .bist_err_cnt(be5)
  );

  logic       f5_co = 1'b0;
  logic [5:0] t5, p5_0, p5_1, p5_2;
  assign t5 = {1'b0, aa5} + {1'b0, ab5} + 6'(ac5);
  always @(posedge clk) begin
    p5_0 <= t5 & ~{f5_co, 5'b00000};
    p5_1 <= p5_0;
    p5_2 <= p5_1;
  end
  assign as5 = p5_2[4:0];
  assign ao5 = p5_2[5];

  logic seen_sv5 = 1'b0;
  always @(posedge clk) if (sv5) seen_sv5 = 1'b1;

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural adder result as seen by the controller, given the active faults.
  function automatic int unsigned ref_obs(input int unsigned a, input int unsigned b,
                                          input int unsigned cin, input bit b3,
                                          input bit co, input int unsigned w);
    int unsigned t;
    t = a + b + cin;
    if (b3) t = t & ~32'd8;
    if (co) t = t & ~(32'd1 << w);
    return t;
  endfunction

  // Issue one request on the 7-bit instance; returns edges from accept to res_valid.
  task automatic req7(input logic [W7-1:0] a, input logic [W7-1:0] b, input logic cin,
                      output int lat);
    @(negedge clk);
    chk("req_ready_idle", 32'(rr7), 32'd1);
    rv7 = 1'b1; ra7 = a; rb7 = b; rc7 = cin;
    @(posedge clk); #1;
    rv7 = 1'b0;
    chk("adder_a_drive", 32'(aa7), 32'(a));
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (sv7) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_res7(input string tag, input int unsigned a, input int unsigned b,
                            input int unsigned cin, input int lat);
    int unsigned o;
    o = ref_obs(a, b, cin, f7_b3, f7_co, W7);
    chk({tag, "_latency"}, 32'(lat), 32'(SC + 1));
    chk({tag, "_sum"}, 32'(ss7), o & 32'h7F);
    chk({tag, "_cout"}, 32'(so7), (o >> W7) & 32'd1);
    chk({tag, "_mismatch"}, 32'(sm7), 32'(o != a + b + cin));
  endtask

  task automatic drain7;
    @(negedge clk);
    sr7 = 1'b1;
    @(posedge clk); #1;
    chk("res_valid_drop", 32'(sv7), 32'd0);
    chk("req_ready_back", 32'(rr7), 32'd1);
    @(negedge clk);
    sr7 = 1'b0;
  endtask

  // Run a sweep on the 5-bit instance with a simultaneous request.
  task automatic sweep5(input string tag, input int unsigned exp_err);
    int cyc;
    @(negedge clk);
    seen_sv5 = 1'b0;
    bs5 = 1'b1; rv5 = 1'b1; ra5 = 5'h1F; rb5 = 5'h11; rc5 = 1'b1;
    #1;
    chk({tag, "_req_ready_masked"}, 32'(rr5), 32'd0);
    @(posedge clk); #1;
    bs5 = 1'b0; rv5 = 1'b0;
    chk({tag, "_busy"}, 32'(bb5), 32'd1);
    chk({tag, "_done_clear"}, 32'(bd5), 32'd0);
    chk({tag, "_err_clear"}, 32'(be5), 32'd0);
    chk({tag, "_req_not_taken"}, 32'({ac5, ab5, aa5}), 32'd0);
    cyc = 0;
    while (cyc < int'(SWEEP5) + 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bd5) break;
    end
    chk({tag, "_sweep_cycles"}, 32'(cyc), 32'(SWEEP5));
    chk({tag, "_done"}, 32'(bd5), 32'd1);
    chk({tag, "_busy_end"}, 32'(bb5), 32'd0);
    chk({tag, "_err_cnt"}, 32'(be5), 32'(exp_err));
    chk({tag, "_no_result"}, 32'(seen_sv5), 32'd0);
    chk({tag, "_idle_after"}, 32'(rr5), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_hold"}, 32'({bd5, be5}), 32'({1'b1, 8'(exp_err)}));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int lat;
    int unsigned a, b, c, n_co;
    logic stable;
    logic [W7-1:0] hs;
    logic          hc, hm;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", 32'(sv7), 32'd0);
    chk("rst_req_ready", 32'(rr7), 32'd0);
    chk("rst_adder", 32'({ac7, ab7, aa7}), 32'd0);
    chk("rst_res", 32'({sm7, so7, ss7}), 32'd0);
    chk("rst_bist", 32'({bb7, bd7, be7}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Basic request with carry out and latency
    req7(7'h55, 7'h2B, 1'b1, lat);
    check_res7("basic", 32'h55, 32'h2B, 1, lat);
    chk("basic_sum_const", 32'(ss7), 32'h01);

    // Back-pressure: result held stable, no new request accepted
    hs = ss7; hc = so7; hm = sm7; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ss7 !== hs || so7 !== hc || sm7 !== hm || sv7 !== 1'b1 || rr7 !== 1'b0) stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 32'd1);
    drain7();

    // Stuck-at-0 on sum bit 3
    f7_b3 = 1'b1;
    req7(7'h08, 7'h00, 1'b0, lat);
    check_res7("stuck_b3", 32'h08, 32'h00, 0, lat);
    drain7();
    f7_b3 = 1'b0;

    // Random requests with random faults and back-pressure
    for (int k = 0; k < 16; k++) begin
      a = $urandom_range(0, 127);
      b = $urandom_range(0, 127);
      c = $urandom_range(0, 1);
      f7_b3 = 1'($urandom_range(0, 3) == 0);
      f7_co = 1'($urandom_range(0, 3) == 0);
      req7(7'(a), 7'(b), 1'(c), lat);
      check_res7("rand", a, b, c, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      drain7();
    end
    f7_b3 = 1'b0; f7_co = 1'b0;

    // Asynchronous reset during SETTLE aborts the operation
    @(negedge clk);
    rv7 = 1'b1; ra7 = 7'h7F; rb7 = 7'h7F; rc7 = 1'b1;
    @(posedge clk); #1;
    rv7 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_adder", 32'({ac7, ab7, aa7}), 32'd0);
    chk("abort_res", 32'({sv7, sm7, so7, ss7}), 32'd0);
    chk("abort_req_ready", 32'(rr7), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_result", 32'(sv7), 32'd0);
    req7(7'h3C, 7'h41, 1'b0, lat);
    check_res7("after_abort", 32'h3C, 32'h41, 0, lat);
    drain7();

    // Clean exhaustive sweep
    sweep5("bist_clean", 0);

    // Sweep with carry-out stuck at 0; count vectors whose true sum overflows
    n_co = 0;
    for (int i = 0; i < (1 << W5); i++)
      for (int j = 0; j < (1 << W5); j++)
        for (int k = 0; k < 2; k++)
          if (i + j + k >= (1 << W5)) n_co++;
    f5_co = 1'b1;
    sweep5("bist_cout", (n_co > 255) ? 255 : n_co);
    f5_co = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
